// File: rtl/decode_exec_pipe_reg.sv
// decode_exec_pipe_reg: decode->exec pipeline register with valid/ready
// handshake, flush, sticky halt and in-register operand forwarding, so a
// held instruction's source operands track younger writebacks while exec
// stalls.
//
// Optional feature: define SKID_BUFFER_EN to add a second (skid) entry and
// make dec_ready a registered output, cutting the exe_ready->dec_ready path.
// Without the macro the register holds a single entry.
module decode_exec_pipe_reg #(
    parameter int WORD_W   = 32,
    parameter int REG_W    = 5,
    parameter int CTRL_W   = 16,
    parameter int HALT_BIT = 15,
    parameter int FWD_SRCS = 2
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       flush,
    input  logic                       dec_valid,
    output logic                       dec_ready,
    input  logic [WORD_W-1:0]          dec_in1,
    input  logic [WORD_W-1:0]          dec_in2,
    input  logic [WORD_W-1:0]          dec_store,
    input  logic [REG_W-1:0]           dec_rs,
    input  logic [REG_W-1:0]           dec_rt,
    input  logic                       dec_use_rs,
    input  logic                       dec_use_rt,
    input  logic [REG_W-1:0]           dec_wsel,
    input  logic [CTRL_W-1:0]          dec_ctrl,
    input  logic [WORD_W-1:0]          dec_npc,
    input  logic [WORD_W-1:0]          dec_tgt,
    input  logic [FWD_SRCS-1:0]        fwd_valid,
    input  logic [FWD_SRCS*REG_W-1:0]  fwd_wsel,
    input  logic [FWD_SRCS*WORD_W-1:0] fwd_wdat,
    output logic                       exe_valid,
    input  logic                       exe_ready,
    output logic [WORD_W-1:0]          exe_in1,
    output logic [WORD_W-1:0]          exe_in2,
    output logic [WORD_W-1:0]          exe_store,
    output logic [REG_W-1:0]           exe_rs,
    output logic [REG_W-1:0]           exe_rt,
    output logic [REG_W-1:0]           exe_wsel,
    output logic [CTRL_W-1:0]          exe_ctrl,
    output logic [WORD_W-1:0]          exe_npc,
    output logic [WORD_W-1:0]          exe_tgt,
    output logic                       halted
);

    typedef struct packed {
        logic [WORD_W-1:0] in1;
        logic [WORD_W-1:0] in2;
        logic [WORD_W-1:0] store;
        logic [REG_W-1:0]  rs;
        logic [REG_W-1:0]  rt;
        logic              use_rs;
        logic              use_rt;
        logic [REG_W-1:0]  wsel;
        logic [CTRL_W-1:0] ctrl;
        logic [WORD_W-1:0] npc;
        logic [WORD_W-1:0] tgt;
    } entry_t;

    // Lowest-index matching source wins; register 0 is hard-wired and never forwarded.
    function automatic logic [WORD_W-1:0] fwd_val(input logic [REG_W-1:0]  r,
                                                  input logic [WORD_W-1:0] v);
        logic [WORD_W-1:0] res;
        res = v;
        for (int i = FWD_SRCS - 1; i >= 0; i--) begin
            if (fwd_valid[i] && (fwd_wsel[i*REG_W +: REG_W] == r) && (r != '0)) begin
                res = fwd_wdat[i*WORD_W +: WORD_W];
            end
        end
        return res;
    endfunction

    // Refresh the register-sourced operands of an entry; ctrl/wsel/npc/tgt stay frozen.
    function automatic entry_t fwd_entry(input entry_t e);
        entry_t r;
        r       = e;
        r.in1   = e.use_rs ? fwd_val(e.rs, e.in1) : e.in1;
        r.in2   = e.use_rt ? fwd_val(e.rt, e.in2) : e.in2;
        r.store = fwd_val(e.rt, e.store);
        return r;
    endfunction

    entry_t dec_entry;
    entry_t main_q, main_d;
    logic   main_v_q, main_v_d;
    logic   halted_q, halted_d;
    logic   accept, consume;

    // Pack the decode-side fields into one entry.
    always_comb begin
        dec_entry = '{in1: dec_in1, in2: dec_in2, store: dec_store,
                      rs: dec_rs, rt: dec_rt, use_rs: dec_use_rs, use_rt: dec_use_rt,
                      wsel: dec_wsel, ctrl: dec_ctrl, npc: dec_npc, tgt: dec_tgt};
    end

    assign accept  = dec_valid && dec_ready;
    assign consume = main_v_q && exe_ready;

`ifdef SKID_BUFFER_EN
    entry_t skid_q, skid_d;
    logic   skid_v_q, skid_v_d;
    logic   ready_q, ready_d;

    assign dec_ready = ready_q;

    // Next state for main + skid entries; order is main first, skid second.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        main_d   = main_q;
        main_v_d = main_v_q;
        skid_d   = skid_q;
        skid_v_d = skid_v_q;
        halted_d = halted_q;
        if (flush) begin
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
        end else begin
            if (skid_v_q) begin
                skid_d = fwd_entry(skid_q);
            end
            if (consume) begin
                if (skid_v_q) begin
                    main_d   = fwd_entry(skid_q);
                    skid_v_d = 1'b0;
                end else if (accept) begin
                    main_d = fwd_entry(dec_entry);
                end else begin
                    main_v_d = 1'b0;
                end
            end else if (accept) begin
                if (main_v_q) begin
                    main_d   = fwd_entry(main_q);
                    skid_d   = fwd_entry(dec_entry);
                    skid_v_d = 1'b1;
                end else begin
                    main_d   = fwd_entry(dec_entry);
                    main_v_d = 1'b1;
                end
            end else if (main_v_q) begin
                main_d = fwd_entry(main_q);
            end
            // A flushed accept never reaches exec, so it cannot halt the pipe.
            if (accept) begin
                halted_d = halted_q | dec_ctrl[HALT_BIT];
            end
        end
        ready_d = !halted_d && !skid_v_d;
    end
`else
    assign dec_ready = !halted_q && (!main_v_q || exe_ready);

    // Next state for the single entry: flush, then accept, consume, or hold+forward.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        main_d   = main_q;
        main_v_d = main_v_q;
        halted_d = halted_q;
        if (flush) begin
            main_v_d = 1'b0;
        end else if (accept) begin
            main_d   = fwd_entry(dec_entry);
            main_v_d = 1'b1;
            halted_d = halted_q | dec_ctrl[HALT_BIT];
        end else if (consume) begin
            main_v_d = 1'b0;
        end else if (main_v_q) begin
            main_d = fwd_entry(main_q);
        end
    end
`endif

    // State register with synchronous reset.
    always_ff @(posedge CLK) begin
        // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
        if (RST) begin
            // NOTE: the payload is reset too because exec observes it as all-zero after reset.
            main_q   <= '0;
            main_v_q <= 1'b0;
            halted_q <= 1'b0;
`ifdef SKID_BUFFER_EN
            skid_q   <= '0;
            skid_v_q <= 1'b0;
            ready_q  <= 1'b1;
`endif
        end else begin
            main_q   <= main_d;
            main_v_q <= main_v_d;
            halted_q <= halted_d;
`ifdef SKID_BUFFER_EN
            skid_q   <= skid_d;
            skid_v_q <= skid_v_d;
            ready_q  <= ready_d;
`endif
        end
    end

    assign exe_valid = main_v_q;
    assign exe_in1   = main_q.in1;
    assign exe_in2   = main_q.in2;
    assign exe_store = main_q.store;
    assign exe_rs    = main_q.rs;
    assign exe_rt    = main_q.rt;
    assign exe_wsel  = main_q.wsel;
    assign exe_ctrl  = main_q.ctrl;
    assign exe_npc   = main_q.npc;
    assign exe_tgt   = main_q.tgt;
    assign halted    = halted_q;

endmodule

// File: tb/tb_decode_exec_pipe_reg.sv
// Testbench for decode_exec_pipe_reg: directed scenarios plus randomized
// traffic against a queue-based reference model of the pipeline register.
module tb_decode_exec_pipe_reg;

    logic        CLK = 1'b0;
    logic        RST, flush, dec_valid, dec_ready;
    logic [31:0] dec_in1, dec_in2, dec_store, dec_npc, dec_tgt;
    logic [4:0]  dec_rs, dec_rt, dec_wsel;
    logic        dec_use_rs, dec_use_rt;
    logic [15:0] dec_ctrl;
    logic [1:0]  fwd_valid;
    logic [9:0]  fwd_wsel;
    logic [63:0] fwd_wdat;
    logic        exe_valid, exe_ready, halted;
    logic [31:0] exe_in1, exe_in2, exe_store, exe_npc, exe_tgt;
    logic [4:0]  exe_rs, exe_rt, exe_wsel;
    logic [15:0] exe_ctrl;

    int checks   = 0;
    int failures = 0;

    decode_exec_pipe_reg dut (
        .CLK(CLK), .RST(RST), .flush(flush),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_in1(dec_in1), .dec_in2(dec_in2), .dec_store(dec_store),
        .dec_rs(dec_rs), .dec_rt(dec_rt), .dec_use_rs(dec_use_rs), .dec_use_rt(dec_use_rt),
        .dec_wsel(dec_wsel), .dec_ctrl(dec_ctrl), .dec_npc(dec_npc), .dec_tgt(dec_tgt),
        .fwd_valid(fwd_valid), .fwd_wsel(fwd_wsel), .fwd_wdat(fwd_wdat),
        .exe_valid(exe_valid), .exe_ready(exe_ready),
        .exe_in1(exe_in1), .exe_in2(exe_in2), .exe_store(exe_store),
        .exe_rs(exe_rs), .exe_rt(exe_rt), .exe_wsel(exe_wsel), .exe_ctrl(exe_ctrl),
        .exe_npc(exe_npc), .exe_tgt(exe_tgt), .halted(halted)
    );

    always #5 CLK = ~CLK;

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] in1, in2, store, npc, tgt;
        logic [4:0]  rs, rt, wsel;
        logic        use_rs, use_rt;
        logic [15:0] ctrl;
    } ent_t;

    ent_t q[$];      // instructions in flight, oldest first
    ent_t shown;     // what the exe_* outputs present
    bit   m_halted;

`ifdef SKID_BUFFER_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    function automatic logic [31:0] f(input logic [4:0] r, input logic [31:0] v);
        if (r == 5'd0) return v;
        for (int i = 0; i < 2; i++)
            if (fwd_valid[i] && fwd_wsel[i*5 +: 5] == r) return fwd_wdat[i*32 +: 32];
        return v;
    endfunction

    function automatic ent_t fwd_e(input ent_t e);
        ent_t r = e;
        if (e.use_rs) r.in1 = f(e.rs, e.in1);
        if (e.use_rt) r.in2 = f(e.rt, e.in2);
        r.store = f(e.rt, e.store);
        return r;
    endfunction

    function automatic bit m_ready();
        if (m_halted) return 1'b0;
        if (DEPTH == 2) return q.size() < 2;
        return q.size() == 0 || exe_ready;
    endfunction

    function automatic logic [190:0] pack_e(input ent_t e);
        return {e.in1, e.in2, e.store, e.rs, e.rt, e.wsel, e.ctrl, e.npc, e.tgt};
    endfunction

    function automatic ent_t cur_dec();
        ent_t e;
        e.in1 = dec_in1; e.in2 = dec_in2; e.store = dec_store;
        e.rs = dec_rs; e.rt = dec_rt; e.use_rs = dec_use_rs; e.use_rt = dec_use_rt;
        e.wsel = dec_wsel; e.ctrl = dec_ctrl; e.npc = dec_npc; e.tgt = dec_tgt;
        return e;
    endfunction

    function automatic ent_t rand_ent();
        ent_t e;
        e.in1 = $urandom; e.in2 = $urandom; e.store = $urandom;
        e.npc = $urandom; e.tgt = $urandom;
        e.rs = 5'($urandom_range(0, 7)); e.rt = 5'($urandom_range(0, 7));
        e.wsel = 5'($urandom_range(0, 31));
        e.use_rs = 1'($urandom_range(0, 1)); e.use_rt = 1'($urandom_range(0, 1));
        e.ctrl = 16'($urandom_range(0, 32767));
        if ($urandom_range(0, 39) == 0) e.ctrl[15] = 1'b1;
        return e;
    endfunction

    function automatic ent_t mk(input logic [31:0] in1, input logic [31:0] in2,
                                input logic [4:0] rs, input logic [4:0] rt,
                                input logic use_rs, input logic use_rt,
                                input logic [15:0] ctrl);
        ent_t e;
        e.in1 = in1; e.in2 = in2; e.store = in2 ^ 32'hFFFF_0000;
        e.rs = rs; e.rt = rt; e.use_rs = use_rs; e.use_rt = use_rt;
        e.wsel = 5'd9; e.ctrl = ctrl; e.npc = 32'h100; e.tgt = 32'h200;
        return e;
    endfunction

    task automatic load_dec(input ent_t e);
        dec_in1 = e.in1; dec_in2 = e.in2; dec_store = e.store;
        dec_rs = e.rs; dec_rt = e.rt; dec_use_rs = e.use_rs; dec_use_rt = e.use_rt;
        dec_wsel = e.wsel; dec_ctrl = e.ctrl; dec_npc = e.npc; dec_tgt = e.tgt;
    endtask

    task automatic idle();
        flush = 1'b0; dec_valid = 1'b0; fwd_valid = 2'b00;
    endtask

    // One clock: advance the model from the inputs in force at the edge.
    task automatic tick();
        bit acc, con;
        acc = dec_valid && m_ready();
        con = (q.size() > 0) && exe_ready;
        @(posedge CLK);
        if (RST) begin
            q.delete();
            shown = '{default: '0};
            m_halted = 1'b0;
        end else if (flush) begin
            if (q.size() > 0) shown = q[0];
            q.delete();
        end else begin
            if (con) shown = q.pop_front();
            foreach (q[i]) q[i] = fwd_e(q[i]);
            if (acc) begin
                q.push_back(fwd_e(cur_dec()));
                if (dec_ctrl[15]) m_halted = 1'b1;
            end
            if (q.size() > 0) shown = q[0];
        end
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        RST = 1'b1; idle(); exe_ready = 1'b0;
        load_dec(mk(32'h1, 32'h2, 5'd1, 5'd2, 1'b1, 1'b1, 16'h0));
        tick(); tick();
        RST = 1'b0;
        #1;
        checks++; if (exe_valid !== 1'b0) begin failures++; $display("FAIL reset_exe_valid got=%b exp=0", exe_valid); end
        checks++; if (halted !== 1'b0) begin failures++; $display("FAIL reset_halted got=%b exp=0", halted); end
        checks++; if (exe_in1 !== 32'h0) begin failures++; $display("FAIL reset_exe_in1 got=%h exp=0", exe_in1); end
        checks++; if (dec_ready !== 1'b1) begin failures++; $display("FAIL reset_dec_ready got=%b exp=1", dec_ready); end
        checks++;
        if ({exe_in2, exe_store, exe_rs, exe_rt, exe_wsel, exe_ctrl, exe_npc, exe_tgt} !== '0) begin
            failures++; $display("FAIL reset_exe_fields got=%h exp=0",
                {exe_in2, exe_store, exe_rs, exe_rt, exe_wsel, exe_ctrl, exe_npc, exe_tgt});
        end
    endtask

    task automatic test_capture_fwd();
        exe_ready = 1'b1; dec_valid = 1'b1;
        load_dec(mk(32'h5, 32'h6, 5'd3, 5'd3, 1'b1, 1'b0, 16'h0));
        fwd_valid = 2'b01; fwd_wsel = {5'd0, 5'd3}; fwd_wdat = {32'h0, 32'hAA};
        tick();
        checks++; if (exe_valid !== 1'b1) begin failures++; $display("FAIL cap_valid got=%b exp=1", exe_valid); end
        checks++; if (exe_in1 !== 32'hAA) begin failures++; $display("FAIL cap_in1 got=%h exp=000000aa", exe_in1); end
        checks++; if (exe_in2 !== 32'h6) begin failures++; $display("FAIL cap_in2_immediate got=%h exp=00000006", exe_in2); end
        checks++; if (exe_store !== 32'hAA) begin failures++; $display("FAIL cap_store got=%h exp=000000aa", exe_store); end
        idle(); tick();
        checks++; if (exe_valid !== 1'b0) begin failures++; $display("FAIL cap_drain_valid got=%b exp=0", exe_valid); end
        checks++; if (exe_in1 !== 32'hAA) begin failures++; $display("FAIL cap_keep_in1 got=%h exp=000000aa", exe_in1); end
    endtask

    task automatic test_hold_fwd();
        exe_ready = 1'b0; dec_valid = 1'b1;
        load_dec(mk(32'h77, 32'h55, 5'd0, 5'd7, 1'b1, 1'b1, 16'h0));
        tick();
        idle();
        fwd_valid = 2'b10; fwd_wsel = {5'd7, 5'd0}; fwd_wdat = {32'h11, 32'h0};
        #1;
        checks++; if (dec_ready !== m_ready()) begin failures++; $display("FAIL hold_dec_ready got=%b exp=%b", dec_ready, m_ready()); end
        tick();
        checks++; if (exe_in2 !== 32'h11) begin failures++; $display("FAIL hold_fwd1_in2 got=%h exp=00000011", exe_in2); end
        checks++; if (exe_store !== 32'h11) begin failures++; $display("FAIL hold_fwd1_store got=%h exp=00000011", exe_store); end
        fwd_valid = 2'b11; fwd_wsel = {5'd7, 5'd7}; fwd_wdat = {32'h33, 32'h22};
        tick();
        checks++; if (exe_in2 !== 32'h22) begin failures++; $display("FAIL hold_prio_in2 got=%h exp=00000022", exe_in2); end
        fwd_valid = 2'b11; fwd_wsel = {5'd0, 5'd0}; fwd_wdat = {32'hDEAD, 32'hBEEF};
        tick();
        checks++; if (exe_in1 !== 32'h77) begin failures++; $display("FAIL hold_r0_in1 got=%h exp=00000077", exe_in1); end
        checks++; if (exe_valid !== 1'b1) begin failures++; $display("FAIL hold_valid got=%b exp=1", exe_valid); end
        idle(); exe_ready = 1'b1; tick();
        // rt = 0 must never pick up a forwarded value, at capture or while held.
        dec_valid = 1'b1; exe_ready = 1'b0;
        load_dec(mk(32'h1, 32'h99, 5'd0, 5'd0, 1'b0, 1'b1, 16'h0));
        fwd_valid = 2'b01; fwd_wsel = {5'd0, 5'd0}; fwd_wdat = {32'h0, 32'hEE};
        tick();
        dec_valid = 1'b0; tick();
        checks++; if (exe_in2 !== 32'h99) begin failures++; $display("FAIL hold_rt0_in2 got=%h exp=00000099", exe_in2); end
        idle(); exe_ready = 1'b1; tick();
    endtask

    task automatic test_flush();
        exe_ready = 1'b0; dec_valid = 1'b1;
        load_dec(mk(32'h1234, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0, 16'h0));
        tick();
        flush = 1'b1;
        load_dec(mk(32'h5678, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0, 16'h0));
        tick();
        checks++; if (exe_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b exp=0", exe_valid); end
        checks++; if (exe_in1 !== 32'h1234) begin failures++; $display("FAIL flush_keep_in1 got=%h exp=00001234", exe_in1); end
        idle(); tick();
        checks++; if (exe_valid !== 1'b0) begin failures++; $display("FAIL flush_dropped got=%b exp=0", exe_valid); end
    endtask

    task automatic test_halt();
        exe_ready = 1'b0; dec_valid = 1'b1;
        load_dec(mk(32'h42, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0, 16'h8000));
        tick();
        checks++; if (halted !== 1'b1) begin failures++; $display("FAIL halt_set got=%b exp=1", halted); end
        checks++; if (exe_valid !== 1'b1 || exe_ctrl !== 16'h8000) begin
            failures++; $display("FAIL halt_delivered got=%b/%h exp=1/8000", exe_valid, exe_ctrl); end
        checks++; if (dec_ready !== 1'b0) begin failures++; $display("FAIL halt_ready got=%b exp=0", dec_ready); end
        exe_ready = 1'b1;
        load_dec(mk(32'h43, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0, 16'h0));
        tick(); tick();
        checks++; if (exe_valid !== 1'b0 || halted !== 1'b1 || dec_ready !== 1'b0) begin
            failures++; $display("FAIL halt_sticky got=%b%b%b exp=010", exe_valid, halted, dec_ready); end
        idle(); RST = 1'b1; tick(); RST = 1'b0; #1;
        checks++; if (halted !== 1'b0 || dec_ready !== 1'b1) begin
            failures++; $display("FAIL halt_reset got=%b%b exp=01", halted, dec_ready); end
    endtask

    task automatic test_back_to_back();
        exe_ready = 1'b1; dec_valid = 1'b1; fwd_valid = 2'b00;
        for (int k = 0; k < 5; k++) begin
            logic [31:0] v;
            v = 32'h101 * (k + 1);
            load_dec(mk(v, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0, 16'h0));
            tick();
            checks++; if (exe_valid !== 1'b1 || exe_in1 !== v) begin
                failures++; $display("FAIL b2b_%0d got=%b/%h exp=1/%h", k, exe_valid, exe_in1, v); end
        end
        idle(); tick();
    endtask

`ifdef SKID_BUFFER_EN
    task automatic test_skid();
        exe_ready = 1'b0; dec_valid = 1'b1;
        load_dec(mk(32'hA1, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0, 16'h0)); tick();
        load_dec(mk(32'hB2, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0, 16'h0)); tick();
        dec_valid = 1'b0; tick();
        checks++; if (exe_in1 !== 32'hA1 || dec_ready !== 1'b0) begin
            failures++; $display("FAIL skid_full got=%h/%b exp=a1/0", exe_in1, dec_ready); end
        exe_ready = 1'b1; #1;
        checks++; if (exe_valid !== 1'b1 || exe_in1 !== 32'hA1) begin
            failures++; $display("FAIL skid_first got=%b/%h exp=1/a1", exe_valid, exe_in1); end
        tick();
        checks++; if (exe_valid !== 1'b1 || exe_in1 !== 32'hB2) begin
            failures++; $display("FAIL skid_second got=%b/%h exp=1/b2", exe_valid, exe_in1); end
        tick();
        checks++; if (exe_valid !== 1'b0) begin failures++; $display("FAIL skid_drain got=%b exp=0", exe_valid); end
    endtask
`endif

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            RST = m_halted && ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 15) == 0);
            dec_valid = 1'($urandom_range(0, 1));
            exe_ready = ($urandom_range(0, 2) != 0);
            load_dec(rand_ent());
            fwd_valid = 2'($urandom_range(0, 3));
            fwd_wsel = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            fwd_wdat = {$urandom, $urandom};
            #1;
            checks++; if (exe_valid !== (q.size() > 0)) begin
                failures++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, exe_valid, q.size() > 0); end
            checks++; if (dec_ready !== m_ready()) begin
                failures++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, dec_ready, m_ready()); end
            checks++; if (halted !== m_halted) begin
                failures++; $display("FAIL rnd_halted c=%0d got=%b exp=%b", c, halted, m_halted); end
            checks++;
            if ({exe_in1, exe_in2, exe_store, exe_rs, exe_rt, exe_wsel, exe_ctrl, exe_npc, exe_tgt} !== pack_e(shown)) begin
                failures++; $display("FAIL rnd_fields c=%0d got=%h exp=%h", c,
                    {exe_in1, exe_in2, exe_store, exe_rs, exe_rt, exe_wsel, exe_ctrl, exe_npc, exe_tgt}, pack_e(shown));
            end
            tick();
        end
    endtask

    initial begin
        RST = 1'b1; exe_ready = 1'b0; idle();
        fwd_wsel = '0; fwd_wdat = '0;
        shown = '{default: '0}; m_halted = 1'b0;
        load_dec(mk(32'h0, 32'h0, 5'd0, 5'd0, 1'b0, 1'b0, 16'h0));
        test_reset();
        test_capture_fwd();
        test_hold_fwd();
        test_flush();
        test_halt();
        test_back_to_back();
`ifdef SKID_BUFFER_EN
        test_skid();
`endif
        RST = 1'b1; idle(); tick(); RST = 1'b0;
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
